// File: rtl/rv_ctl_hs.sv
// Multicycle RISC-V control FSM with a memory request/ready handshake, wait-state
// timeout, extended instruction subset, sticky HALT/FAULT and a retired counter.
module rv_ctl_hs #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15,
    parameter bit EXT_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       pcsource,
    output logic             pcwrite,
    output logic             pccen,
    output logic             irwrite,
    output logic [1:0]       wbsel,
    output logic             regwen,
    output logic [2:0]       immsel,
    output logic             asel,
    output logic             bsel,
    output logic [3:0]       alusel,
    output logic             mdrwrite,
    output logic             halt,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] WB_PC  = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MDR = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_ALU    = 2'd1;
    localparam logic [1:0] PC_ALUOUT = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_LW_MEM,
        S_LW_WB,
        S_SW_MEM,
        S_ALU_EXEC,
        S_ALU_WB,
        S_BR_EXEC,
        S_JAL_EXEC,
        S_JALR_EXEC,
        S_LUI_WB,
        S_HALT,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              halt_q, halt_d;
    logic              fault_q, fault_d;

    logic       stall;
    logic       retire;
    logic       mem_req_raw, mem_we_raw, pcwrite_raw, pccen_raw, irwrite_raw;
    logic       regwen_raw, asel_raw, bsel_raw, mdrwrite_raw;
    logic [1:0] pcsource_raw, wbsel_raw;
    logic [2:0] immsel_raw;
    logic [3:0] alusel_raw;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7_b5    = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            halt_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            halt_q    <= halt_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        retire       = 1'b0;
        mem_req_raw  = 1'b0;
        mem_we_raw   = 1'b0;
        pcsource_raw = PC_PLUS4;
        pcwrite_raw  = 1'b0;
        pccen_raw    = 1'b0;
        irwrite_raw  = 1'b0;
        wbsel_raw    = WB_PC;
        regwen_raw   = 1'b0;
        immsel_raw   = IMM_I;
        asel_raw     = 1'b0;
        bsel_raw     = 1'b0;
        alusel_raw   = ALU_ADD;
        mdrwrite_raw = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_raw = 1'b1;
                if (mem_ready) begin
                    irwrite_raw  = 1'b1;
                    pccen_raw    = 1'b1;
                    pcwrite_raw  = 1'b1;
                    pcsource_raw = PC_PLUS4;
                    state_d      = S_DECODE;
                end else begin
                    stall = 1'b1;
                end
            end

            // Speculatively form the branch target into ALUOut while decoding.
            S_DECODE: begin
                asel_raw   = 1'b1;
                bsel_raw   = 1'b1;
                immsel_raw = IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R:              state_d = S_ALU_EXEC;
                    OP_IMM:            state_d = EXT_EN ? S_ALU_EXEC : S_FAULT;
                    OP_BRANCH:         state_d = S_BR_EXEC;
                    OP_JAL:            state_d = S_JAL_EXEC;
                    OP_JALR:           state_d = EXT_EN ? S_JALR_EXEC : S_FAULT;
                    OP_LUI:            state_d = EXT_EN ? S_LUI_WB : S_FAULT;
                    OP_SYSTEM:         state_d = S_HALT;
                    default:           state_d = S_FAULT;
                endcase
            end

            S_MEM_ADDR: begin
                bsel_raw = 1'b1;
                if (opcode == OP_LOAD) begin
                    immsel_raw = IMM_I;
                    state_d    = S_LW_MEM;
                end else begin
                    immsel_raw = IMM_S;
                    state_d    = S_SW_MEM;
                end
            end

            S_LW_MEM: begin
                mem_req_raw = 1'b1;
                if (mem_ready) begin
                    mdrwrite_raw = 1'b1;
                    state_d      = S_LW_WB;
                end else begin
                    stall = 1'b1;
                end
            end

            S_LW_WB: begin
                wbsel_raw  = WB_MDR;
                regwen_raw = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_SW_MEM: begin
                mem_req_raw = 1'b1;
                mem_we_raw  = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    stall = 1'b1;
                end
            end

            // Shift-right-immediate is the only OP-IMM form where bit 30 selects the op.
            S_ALU_EXEC: begin
                if (opcode == OP_R) begin
                    bsel_raw   = 1'b0;
                    alusel_raw = {funct3, funct7_b5};
                end else begin
                    bsel_raw   = 1'b1;
                    immsel_raw = IMM_I;
                    alusel_raw = (funct3 == 3'b101) ? {funct3, funct7_b5} : {funct3, 1'b0};
                end
                state_d = S_ALU_WB;
            end

            S_ALU_WB: begin
                wbsel_raw  = WB_ALU;
                regwen_raw = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_BR_EXEC: begin
                alusel_raw   = ALU_SUB;
                pcsource_raw = PC_ALUOUT;
                if (funct3 == 3'b000) begin
                    pcwrite_raw = zero;
                    retire      = 1'b1;
                    state_d     = S_FETCH;
                end else if (funct3 == 3'b001 && EXT_EN) begin
                    pcwrite_raw = !zero;
                    retire      = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_FAULT;
                end
            end

            S_JAL_EXEC: begin
                asel_raw     = 1'b1;
                bsel_raw     = 1'b1;
                immsel_raw   = IMM_J;
                pcsource_raw = PC_ALU;
                pcwrite_raw  = 1'b1;
                regwen_raw   = 1'b1;
                wbsel_raw    = WB_PC;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end

            S_JALR_EXEC: begin
                bsel_raw     = 1'b1;
                immsel_raw   = IMM_I;
                pcsource_raw = PC_ALU;
                pcwrite_raw  = 1'b1;
                regwen_raw   = 1'b1;
                wbsel_raw    = WB_PC;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end

            S_LUI_WB: begin
                immsel_raw = IMM_U;
                wbsel_raw  = WB_IMM;
                regwen_raw = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        // A stalled access that has used up its wait budget aborts into FAULT.
        if (TIMEOUT > 0 && stall && wait_q == WAIT_LAST) begin
            state_d = S_FAULT;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (TIMEOUT > 0 && stall) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end

        halt_d  = (state_d == S_HALT);
        fault_d = (state_d == S_FAULT);
    end

    // Reset forces every control low immediately, even though the FSM sits in FETCH.
    assign mem_req  = rst & mem_req_raw;
    assign mem_we   = rst & mem_we_raw;
    assign pcsource = rst ? pcsource_raw : 2'd0;
    assign pcwrite  = rst & pcwrite_raw;
    assign pccen    = rst & pccen_raw;
    assign irwrite  = rst & irwrite_raw;
    assign wbsel    = rst ? wbsel_raw : 2'd0;
    assign regwen   = rst & regwen_raw;
    assign immsel   = rst ? immsel_raw : 3'd0;
    assign asel     = rst & asel_raw;
    assign bsel     = rst & bsel_raw;
    assign alusel   = rst ? alusel_raw : 4'd0;
    assign mdrwrite = rst & mdrwrite_raw;
    assign halt     = halt_q;
    assign fault    = fault_q;
    assign retired  = retired_q;

endmodule
